// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding valid/ready to APB requester with ACCESS timeout
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int                 c_CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;

    assign req_ready = (r_state == S_IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        PWRITE  <= req_write;
                        PADDR   <= req_addr;
                        PWDATA  <= req_wdata;
                        PSEL    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE    <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY takes precedence over the timeout on the limit edge
                    if (PREADY) begin
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_wait_cnt == c_CNT_LIMIT) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Directed self-checking bench for apb_master_bridge with APB slave model
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int c_DW      = 32;
    localparam int c_AW      = 10;
    localparam int c_TIMEOUT = 16;

    localparam int c_MODE_RAM  = 0;
    localparam int c_MODE_HANG = 1;
    localparam int c_MODE_ERR  = 2;
    localparam int c_MODE_LATE = 3;

    logic            PCLK;
    logic            PRESET;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [c_AW-1:0] req_addr;
    logic [c_DW-1:0] req_wdata;
    logic            rsp_valid;
    logic [c_DW-1:0] rsp_rdata;
    logic            rsp_err;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [c_AW-1:0] PADDR;
    logic [c_DW-1:0] PWDATA;
    logic [c_DW-1:0] PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    int vectors;
    int miscompares;
    int mode;

    apb_master_bridge #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // APB slave model: RAM-style registered PREADY, plus hang/error/late variants
    logic [c_DW-1:0] mem [0:(1<<c_AW)-1];
    int              late_cnt;
    logic            w_first_access;
    assign w_first_access = PSEL && PENABLE && !PREADY;

    always @(posedge PCLK) begin
        case (mode)
            c_MODE_RAM: begin
                PREADY  <= w_first_access;
                PSLVERR <= 1'b0;
                if (w_first_access) begin
                    if (PWRITE) mem[PADDR] <= PWDATA;
                    PRDATA <= mem[PADDR];
                end
            end
            c_MODE_HANG: begin
                PREADY  <= 1'b0;
                PSLVERR <= 1'b0;
            end
            c_MODE_ERR: begin
                PREADY  <= w_first_access;
                PSLVERR <= w_first_access;
                PRDATA  <= 32'h1234_5678;
            end
            default: begin
                PSLVERR <= 1'b0;
                PRDATA  <= 32'hA5A5_A5A5;
                PREADY  <= PSEL && PENABLE && (late_cnt == c_TIMEOUT - 2);
                late_cnt <= (PSEL && PENABLE) ? late_cnt + 1 : 0;
            end
        endcase
    end

    // Present one command at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic wr, input logic [c_AW-1:0] addr, input logic [c_DW-1:0] data);
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen; -1 on expiry
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE});
        end
        vectors++;
        if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", PADDR, PWDATA, rsp_rdata);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_write_read();
        int n;
        mode = c_MODE_RAM;
        issue(1'b1, 10'h005, 32'hDEAD_BEEF);
        vectors++;
        if ({PSEL, PENABLE, req_ready, PWRITE} !== 4'b1001 || PADDR !== 10'h005 || PWDATA !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL wr_setup: sel/en/rdy/wr=%b addr=%h wdata=%h want 1001 005 deadbeef", {PSEL, PENABLE, req_ready, PWRITE}, PADDR, PWDATA);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            vectors++;
            if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b1100 || PADDR !== 10'h005 || PWDATA !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("FAIL wr_access%0d: sel/en/rdy/rv=%b addr=%h wdata=%h want 1100 005 deadbeef", k, {PSEL, PENABLE, req_ready, rsp_valid}, PADDR, PWDATA);
            end
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, PSEL, PENABLE, req_ready} !== 5'b10000 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_resp: rv/err/sel/en/rdy=%b rdata=%h want 10000 0", {rsp_valid, rsp_err, PSEL, PENABLE, req_ready}, rsp_rdata);
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_idle: rv/rdy=%b want 01", {rsp_valid, req_ready});
        end
        issue(1'b0, 10'h005, 32'h0);
        wait_rsp(n);
        vectors++;
        if (n !== 3 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_after_wr: lat=%0d rdata=%h err=%b want 3 deadbeef 0", n, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_timeout();
        int n;
        mode = c_MODE_HANG;
        issue(1'b0, 10'h3FF, 32'h0);
        wait_rsp(n);
        vectors++;
        if (n !== c_TIMEOUT + 1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: lat=%0d err=%b rdata=%h sel=%b en=%b want %0d 1 0 0 0", n, rsp_err, rsp_rdata, PSEL, PENABLE, c_TIMEOUT + 1);
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, req_ready, rsp_err} !== 3'b011) begin
            miscompares++;
            $display("FAIL timeout_hold: rv/rdy/err=%b want 011", {rsp_valid, req_ready, rsp_err});
        end
    endtask

    task automatic test_slverr();
        int n;
        mode = c_MODE_ERR;
        issue(1'b0, 10'h020, 32'h0);
        wait_rsp(n);
        vectors++;
        if (n !== 3 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL slverr: lat=%0d err=%b rdata=%h want 3 1 0", n, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int issued, inflight, rsps, setups;
        mode     = c_MODE_RAM;
        issued   = 0;
        inflight = 0;
        rsps     = 0;
        setups   = 0;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h000;
        req_wdata = 32'h0000_0100;
        for (int cyc = 0; cyc < 80 && rsps < 4; cyc++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                setups++;
                inflight = issued;
                issued++;
                if (issued == 4) req_valid = 1'b0;
                else begin
                    req_addr  = c_AW'(issued);
                    req_wdata = 32'h0000_0100 + 32'(issued);
                end
            end
            if (PSEL) begin
                vectors++;
                if (PADDR !== c_AW'(inflight) || req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_xfer: paddr=%h rdy=%b want %h 0", PADDR, req_ready, inflight);
                end
            end
            if (rsp_valid) begin
                vectors++;
                if (PADDR !== c_AW'(rsps) || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_rsp: paddr=%h err=%b rdy=%b want %h 0 0", PADDR, rsp_err, req_ready, rsps);
                end
                rsps++;
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (rsps !== 4 || setups !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: rsps=%0d setups=%0d want 4 4", rsps, setups);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        int n, seen;
        mode = c_MODE_RAM;
        issue(1'b0, 10'h005, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_mid: sel/en/rdy/rv=%b want 0010", {PSEL, PENABLE, req_ready, rsp_valid});
        end
        PRESET = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (rsp_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_norsp: pulses=%0d want 0", seen);
        end
        issue(1'b0, 10'h005, 32'h0);
        wait_rsp(n);
        vectors++;
        if (n !== 3 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_next: lat=%0d rdata=%h err=%b want 3 deadbeef 0", n, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_late_ready();
        int n;
        mode = c_MODE_LATE;
        issue(1'b0, 10'h010, 32'h0);
        wait_rsp(n);
        vectors++;
        if (n !== c_TIMEOUT + 1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL late_ready: lat=%0d err=%b rdata=%h want %0d 0 a5a5a5a5", n, rsp_err, rsp_rdata, c_TIMEOUT + 1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = c_MODE_RAM;
        late_cnt    = 0;
        PRESET      = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        test_reset();
        test_write_read();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        test_late_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester for the APB RAM interface. It accepts single read/write commands on a simple valid/ready request port. Each command becomes one APB transfer: a SETUP phase, then an ACCESS phase that waits for PREADY. The block returns read data and error status on a one-cycle response strobe. An ACCESS-phase timeout guards against a slave that never answers.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA and the request/response data
- ADDR_WIDTH, 10, width of PADDR and req_addr
- TIMEOUT, 16, maximum ACCESS-phase cycles without PREADY before abort (legal range 1..255)

Ports:
- PCLK  in  1  single clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- req_valid  in  1  command present
- req_ready  out  1  block can accept a command
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion strobe; no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
- rsp_err  out  1  PSLVERR seen or timeout; valid with rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states:
  - IDLE: req_ready=1; PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - RESP: rsp_valid=1; PSEL=0, PENABLE=0.
- IDLE→SETUP when req_valid && req_ready at a clock edge. On that same edge, latch req_write, req_addr and req_wdata into PWRITE, PADDR and PWDATA.
- PWRITE, PADDR and PWDATA hold stable from SETUP through the end of ACCESS.
- SETUP→ACCESS unconditionally after 1 cycle.
- ACCESS→RESP at the first edge where PREADY=1:
  - rsp_err ← PSLVERR.
  - rsp_rdata ← (!PWRITE && !PSLVERR) ? PRDATA : 0.
- ACCESS→RESP on timeout when the wait counter reaches TIMEOUT−1 and PREADY=0: rsp_err←1, rsp_rdata←0.
  - If PREADY=1 on the same edge as the counter limit, PREADY wins and the transfer completes normally.
- Wait counter:
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to ACCESS.
  - Increments each ACCESS cycle with PREADY=0.
  - Never wraps.
- RESP→IDLE unconditionally after 1 cycle.
- rsp_rdata and rsp_err hold their values until the next RESP.
- One outstanding transfer only. req_ready=0 in SETUP, ACCESS and RESP.
- PRESET has priority over all transitions. It forces IDLE from any state, including mid-ACCESS; the in-flight transfer is dropped with no response.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0; counter 0.

## Timing
- All outputs are registered. req_ready is a decode of the state register.
- Accept at edge E0 → SETUP in cycle E0..E1 → ACCESS starts at E1.
- If PREADY is sampled high at edge E1+n (n≥1), rsp_valid is high during cycle E1+n..E2+n. req_ready returns at E2+n.
- With the RAM interface as slave, the slave registers PREADY one cycle after PSEL&&PENABLE. ACCESS therefore lasts 2 cycles, and accept-to-rsp_valid is 3 edges.
- The next command can be accepted at the first edge after RESP. Minimum command period is 4 cycles when ACCESS lasts 1 cycle.
- Timeout: rsp_valid rises TIMEOUT cycles after ACCESS entry.
- PSEL deasserts and PENABLE drops to 0 on the edge that leaves ACCESS. No back-to-back ACCESS without an intervening SETUP.

## Test plan
- Write then read, with the RAM interface as slave: write addr 0x005, data 0xDEADBEEF; then read addr 0x005.
  - Expect rsp_rdata=0xDEADBEEF, rsp_err=0.
  - Expect APB SETUP 1 cycle, ACCESS 2 cycles, rsp_valid 3 edges after accept.
- Slave model holds PREADY=0 forever, TIMEOUT=16: read 0x3FF.
  - Expect rsp_valid exactly 16 cycles after ACCESS entry, rsp_err=1, rsp_rdata=0, PSEL low the next cycle.
- Slave returns PREADY=1 with PSLVERR=1 and PRDATA=0x12345678 on a read.
  - Expect rsp_err=1, rsp_rdata=0.
- req_valid held high with 4 queued commands (addr 0, 1, 2, 3).
  - Expect exactly 4 rsp_valid pulses in order, each with a SETUP phase.
  - Expect PADDR stable across each SETUP/ACCESS.
  - Expect req_ready low throughout each transfer.
- PRESET asserted during the 2nd ACCESS cycle of a read.
  - Expect at the next edge: PSEL=0, PENABLE=0, req_ready=1.
  - Expect no rsp_valid.
  - Expect the next command to proceed normally.
- PREADY rising on the exact timeout-limit edge, with PRDATA=0xA5A5A5A5.
  - Expect rsp_err=0, rsp_rdata=0xA5A5A5A5.
